// File: rtl/msk_pkg.sv
// rtl/msk_pkg.sv - shared constants and types for the MSK transmit datapath
//
// Contents:
//   WORD_W, DIV_W      word and divisor widths
//   DEFAULT_DIVISOR    carrier_freq / bit_freq for the 300 kHz / 100 bps beacon
//   MIN_DIVISOR        shortest legal bit period in clk cycles
//   PIR_CARRIER/H/L    DDS phase increments, PIR = f * 2^32 / f_clk
//   state_t            sequencer states (IDLE / LOAD / SEND)
package msk_pkg;

    localparam int WORD_W          = 30;
    localparam int DIV_W           = 16;
    localparam int DEFAULT_DIVISOR = 3000;

    // A one-cycle bit would leave no room for the terminal-count tick to be
    // registered ahead of the shift, so the period never drops below two.
    localparam int MIN_DIVISOR     = 2;

    localparam longint unsigned F_CLK_HZ     = 64'd100_000_000;
    localparam longint unsigned F_CARRIER_HZ = 64'd300_000;
    localparam longint unsigned F_BIT_HZ     = F_CARRIER_HZ / 64'(DEFAULT_DIVISOR);

    // MSK tones sit a quarter of the bit rate either side of the carrier,
    // which gives exactly half a cycle of phase difference per bit.
    localparam longint unsigned F_H_HZ = F_CARRIER_HZ + F_BIT_HZ / 64'd4;
    localparam longint unsigned F_L_HZ = F_CARRIER_HZ - F_BIT_HZ / 64'd4;

    // Phase increment for a 32-bit DDS accumulator, rounded to nearest.
    function automatic logic [31:0] pir_of(input longint unsigned f_hz);
        longint unsigned scaled;
        scaled = ((f_hz << 32) + (F_CLK_HZ / 64'd2)) / F_CLK_HZ;
        return scaled[31:0];
    endfunction

    localparam logic [31:0] PIR_CARRIER = pir_of(F_CARRIER_HZ);  // 12884902
    localparam logic [31:0] PIR_H       = pir_of(F_H_HZ);        // 12885976
    localparam logic [31:0] PIR_L       = pir_of(F_L_HZ);        // 12883828

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - bit-period counter with load, clear and terminal-count tick
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   load            latch period_in (clamped to MIN_PERIOD) and restart at count 0
//   period_in       clk cycles per bit
//   clear           return count to 0 without changing the period
//   run             advance the count by one cycle
//   tick            registered; high during the last cycle of each period
module bit_timer #(
    parameter int DIV_W      = msk_pkg::DIV_W,
    parameter int MIN_PERIOD = msk_pkg::MIN_DIVISOR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] period_in,
    input  logic             clear,
    input  logic             run,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last_cnt;
    logic [DIV_W-1:0] cnt_inc;

    assign cnt_inc = cnt + 1'b1;

    // The terminal count is stored as period-1 so the tick can be decided one
    // cycle early and presented as a register during the final cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            last_cnt <= DIV_W'(MIN_PERIOD - 1);
            tick     <= 1'b0;
        end else if (load) begin
            cnt      <= '0;
            tick     <= 1'b0;
            if (period_in < DIV_W'(MIN_PERIOD)) begin
                last_cnt <= DIV_W'(MIN_PERIOD - 1);
            end else begin
                last_cnt <= period_in - 1'b1;
            end
        end else if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (run) begin
            if (cnt == last_cnt) begin
                cnt  <= '0;
                tick <= 1'b0;
            end else begin
                cnt  <= cnt_inc;
                tick <= (cnt_inc == last_cnt);
            end
        end
    end

endmodule

// File: rtl/msk_bit_sequencer.sv
// rtl/msk_bit_sequencer.sv - word buffer and MSB-first bit serializer driving the MSK DDS
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   enable                     transmit while set; clearing it lets the current word finish
//   divisor                    clk cycles per bit, sampled whenever a word is loaded
//   s_word, s_valid, s_ready   word input handshake, one-word holding register
//   bit_out                    current data bit
//   pir_sel                    DDS frequency select, 1 = PIR_H, 0 = PIR_L
//   reset_dds                  one-cycle DDS phase reset at the start of a burst
//   bit_clk_tick               high during the last cycle of each bit
//   word_start                 high during the first cycle of each word
//   busy                       high in LOAD and SEND
//   underrun                   one-cycle pulse: word ended while enabled with nothing buffered
module msk_bit_sequencer #(
    parameter int WORD_W = msk_pkg::WORD_W,
    parameter int DIV_W  = msk_pkg::DIV_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DIV_W-1:0]  divisor,
    input  logic [WORD_W-1:0] s_word,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              bit_out,
    output logic              pir_sel,
    output logic              reset_dds,
    output logic              bit_clk_tick,
    output logic              word_start,
    output logic              busy,
    output logic              underrun
);

    import msk_pkg::state_t;
    import msk_pkg::ST_IDLE;
    import msk_pkg::ST_LOAD;
    import msk_pkg::ST_SEND;

    localparam int              IDX_W    = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    state_t            state;
    logic [WORD_W-1:0] hold;
    logic              hold_valid;
    logic [WORD_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;
    logic              prev;

    logic tick;
    logic accept;
    logic last_tick;
    logic reload;
    logic timer_load;
    logic timer_clear;
    logic timer_run;

    assign s_ready      = ~hold_valid;
    assign accept       = s_valid & ~hold_valid;
    assign bit_clk_tick = tick;

    // A reload happens on the final tick of a word when another word is
    // already waiting; the next word then starts with no gap and no DDS reset.
    assign last_tick = (state == ST_SEND) & tick & (bit_idx == LAST_IDX);
    assign reload    = last_tick & enable & hold_valid;

    // The divisor is latched at every word boundary, so each word may carry
    // its own bit rate.
    assign timer_load  = (state == ST_LOAD) | reload;
    assign timer_clear = (state == ST_IDLE);
    assign timer_run   = (state == ST_SEND);

    bit_timer #(
        .DIV_W (DIV_W)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (timer_load),
        .period_in (divisor),
        .clear     (timer_clear),
        .run       (timer_run),
        .tick      (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            shreg      <= '0;
            bit_idx    <= '0;
            prev       <= 1'b0;
            bit_out    <= 1'b0;
            pir_sel    <= 1'b0;
            reset_dds  <= 1'b0;
            word_start <= 1'b0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            reset_dds  <= 1'b0;
            word_start <= 1'b0;
            underrun   <= 1'b0;

            // Acceptance takes priority over consumption so that a word
            // arriving on the same edge the old one is taken keeps the
            // holding register full.
            if (accept) begin
                hold       <= s_word;
                hold_valid <= 1'b1;
            end else if ((state == ST_LOAD) || reload) begin
                hold_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (enable && hold_valid) begin
                        state     <= ST_LOAD;
                        reset_dds <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    state      <= ST_SEND;
                    shreg      <= hold;
                    bit_idx    <= '0;
                    prev       <= 1'b0;
                    bit_out    <= hold[WORD_W-1];
                    pir_sel    <= hold[WORD_W-1];
                    word_start <= 1'b1;
                end

                ST_SEND: begin
                    if (tick) begin
                        if (bit_idx != LAST_IDX) begin
                            // pir_sel is the differential precoding of the
                            // data: it toggles the tone only when the bit
                            // differs from the one before, keeping phase
                            // continuous across the bit boundary.
                            shreg   <= {shreg[WORD_W-2:0], 1'b0};
                            bit_idx <= bit_idx + 1'b1;
                            prev    <= bit_out;
                            bit_out <= shreg[WORD_W-2];
                            pir_sel <= shreg[WORD_W-2] ^ bit_out;
                        end else if (reload) begin
                            // prev carries the last bit of the old word so the
                            // precoding stays continuous across the boundary.
                            shreg      <= hold;
                            bit_idx    <= '0;
                            prev       <= bit_out;
                            bit_out    <= hold[WORD_W-1];
                            pir_sel    <= hold[WORD_W-1] ^ bit_out;
                            word_start <= 1'b1;
                        end else begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            bit_out  <= 1'b0;
                            pir_sel  <= 1'b0;
                            prev     <= 1'b0;
                            // Reaching here while enabled means the buffer
                            // was empty at the word boundary.
                            underrun <= enable;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msk_bit_sequencer.sv
// tb/tb_msk_bit_sequencer.sv - scoreboard bench for msk_bit_sequencer
`timescale 1ns/1ps
module tb_msk_bit_sequencer;

    localparam int WORD_W = 30;
    localparam int DIV_W  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic [DIV_W-1:0]  divisor = 16'd4;
    logic [WORD_W-1:0] s_word = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              bit_out;
    logic              pir_sel;
    logic              reset_dds;
    logic              bit_clk_tick;
    logic              word_start;
    logic              busy;
    logic              underrun;

    always #5 clk = ~clk;

    msk_bit_sequencer #(
        .WORD_W (WORD_W),
        .DIV_W  (DIV_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .divisor      (divisor),
        .s_word       (s_word),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .bit_out      (bit_out),
        .pir_sel      (pir_sel),
        .reset_dds    (reset_dds),
        .bit_clk_tick (bit_clk_tick),
        .word_start   (word_start),
        .busy         (busy),
        .underrun     (underrun)
    );

    typedef struct {
        logic b;
        logic p;
        int   len;
    } bit_exp_t;

    typedef struct {
        logic [WORD_W-1:0] w;
        int                d;
    } vec_t;

    bit_exp_t exp_q[$];
    bit_exp_t mon_e;

    int   tests = 0;
    int   fails = 0;
    int   tick_total = 0;
    int   ws_total = 0;
    int   rd_total = 0;
    int   ur_total = 0;
    int   send_total = 0;
    int   bit_cycles = 0;
    int   t_base, w_base, r_base, u_base, s_base;
    logic model_prev = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: counts pulses and scores every completed bit against the queue.
    always @(negedge clk) begin
        if (reset_dds)  rd_total++;
        if (word_start) ws_total++;
        if (underrun)   ur_total++;
        if (busy && !reset_dds) begin
            send_total++;
            bit_cycles++;
        end else begin
            bit_cycles = 0;
        end
        if (bit_clk_tick) begin
            tick_total++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_tick: tick %0d with empty queue", tick_total);
            end else begin
                mon_e = exp_q.pop_front();
                check("bit_out", int'(bit_out), int'(mon_e.b));
                check("pir_sel", int'(pir_sel), int'(mon_e.p));
                check("bit_len", bit_cycles, mon_e.len);
            end
            bit_cycles = 0;
        end
    end

    task automatic push_expected(input logic [WORD_W-1:0] w, input int d, input bit new_burst);
        bit_exp_t r;
        if (new_burst) model_prev = 1'b0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            r.b = w[i];
            r.p = w[i] ^ model_prev;
            r.len = (d < 2) ? 2 : d;
            model_prev = w[i];
            exp_q.push_back(r);
        end
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w);
        for (int g = 0; g < 3000 && !s_ready; g++) @(negedge clk);
        check("s_ready_wait", int'(s_ready), 1);
        s_word  = w;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_busy(input logic val, input string name);
        for (int g = 0; g < 3000 && busy != val; g++) @(negedge clk);
        check(name, int'(busy), int'(val));
    endtask

    task automatic snap();
        t_base = tick_total;
        w_base = ws_total;
        r_base = rd_total;
        u_base = ur_total;
        s_base = send_total;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"},   int'(s_ready), 1);
        check({tag, "_bit_out"},   int'(bit_out), 0);
        check({tag, "_pir_sel"},   int'(pir_sel), 0);
        check({tag, "_reset_dds"}, int'(reset_dds), 0);
        check({tag, "_tick"},      int'(bit_clk_tick), 0);
        check({tag, "_word_start"}, int'(word_start), 0);
        check({tag, "_busy"},      int'(busy), 0);
        check({tag, "_underrun"},  int'(underrun), 0);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{w: 30'h20000001, d: 4};
        vecs[1] = '{w: 30'h2AAAAAAA, d: 3};
        vecs[2] = '{w: 30'h3FFFFFFF, d: 2};
        vecs[3] = '{w: 30'h0F0F0F0F, d: 0};
        vecs[4] = '{w: 30'h12345678, d: 1};

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b1;
        @(negedge clk);

        // Single-word bursts; each ends in an underrun with enable held high.
        enable = 1'b1;
        foreach (vecs[k]) begin
            snap();
            divisor = vecs[k].d[DIV_W-1:0];
            push_expected(vecs[k].w, vecs[k].d, 1'b1);
            send_word(vecs[k].w);
            wait_busy(1'b1, "single_start");
            wait_busy(1'b0, "single_end");
            repeat (3) @(negedge clk);
            check("single_ticks", tick_total - t_base, 30);
            check("single_reset_dds", rd_total - r_base, 1);
            check("single_word_start", ws_total - w_base, 1);
            check("single_underrun", ur_total - u_base, 1);
            check("single_send_cycles", send_total - s_base, 30 * ((vecs[k].d < 2) ? 2 : vecs[k].d));
            check("single_queue_empty", exp_q.size(), 0);
            check("single_idle_bit_out", int'(bit_out), 0);
            check("single_idle_pir_sel", int'(pir_sel), 0);
        end

        // Two words back to back: the second reloads seamlessly with precoding
        // continuity; enable drops during the second word so no underrun.
        enable  = 1'b0;
        divisor = 16'd4;
        snap();
        push_expected(30'h3C0F00FF, 4, 1'b1);
        push_expected(30'h15555555, 4, 1'b0);
        send_word(30'h3C0F00FF);
        enable = 1'b1;
        send_word(30'h15555555);
        for (int g = 0; g < 3000 && (ws_total - w_base) < 2; g++) @(negedge clk);
        check("pair_second_start", ws_total - w_base, 2);
        enable = 1'b0;
        wait_busy(1'b0, "pair_end");
        repeat (3) @(negedge clk);
        check("pair_ticks", tick_total - t_base, 60);
        check("pair_reset_dds", rd_total - r_base, 1);
        check("pair_underrun", ur_total - u_base, 0);
        check("pair_send_cycles", send_total - s_base, 240);
        check("pair_queue_empty", exp_q.size(), 0);

        // Enable dropped at bit 5 with the next word buffered.
        enable = 1'b1;
        snap();
        push_expected(30'h3FFF0000, 4, 1'b1);
        push_expected(30'h0000FFFF, 4, 1'b1);
        send_word(30'h3FFF0000);
        send_word(30'h0000FFFF);
        for (int g = 0; g < 3000 && (tick_total - t_base) < 5; g++) @(negedge clk);
        enable = 1'b0;
        wait_busy(1'b0, "drop_end");
        repeat (3) @(negedge clk);
        check("drop_ticks", tick_total - t_base, 30);
        check("drop_word_start", ws_total - w_base, 1);
        check("drop_underrun", ur_total - u_base, 0);
        check("drop_s_ready", int'(s_ready), 0);
        repeat (5) @(negedge clk);
        check("drop_idle_held", int'(busy), 0);
        enable = 1'b1;
        @(negedge clk);
        check("drop_reenable_load", int'(reset_dds), 1);
        wait_busy(1'b0, "drop_second_end");
        repeat (3) @(negedge clk);
        check("drop_total_ticks", tick_total - t_base, 60);
        check("drop_reset_dds", rd_total - r_base, 2);
        check("drop_final_underrun", ur_total - u_base, 1);
        check("drop_queue_empty", exp_q.size(), 0);

        // Reset in the middle of bit 10 with another word buffered.
        divisor = 16'd4;
        snap();
        push_expected(30'h2AAAAAAA, 4, 1'b1);
        send_word(30'h2AAAAAAA);
        send_word(30'h3FFFFFFF);
        for (int g = 0; g < 3000 && (tick_total - t_base) < 10; g++) @(negedge clk);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (5) @(negedge clk);
        check("midrst_ticks", tick_total - t_base, 10);
        check("midrst_remaining", exp_q.size(), 20);
        exp_q.delete();
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_after_s_ready", int'(s_ready), 1);
        check("midrst_after_busy", int'(busy), 0);
        check("midrst_after_ticks", tick_total - t_base, 10);
        enable = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
